// File: rtl/diff_wb_stage_pkg.sv
// diff_wb_stage_pkg: shared constants for the diff writeback stage and its skid buffer.
package diff_wb_stage_pkg;
    localparam int DIFF_EQUAL   = 32;
    localparam int DIFF_MAX_IDX = 31;
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
endpackage

// File: rtl/diff_wb_stage_skid_buffer2.sv
// skid_buffer2: 2-entry valid/ready skid buffer with registered in_ready.
module skid_buffer2
    import diff_wb_stage_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [1:0]   state, state_nxt;
    logic         rdy, acc, drn, load_out, load_skid;
    logic [W-1:0] out_q, skid_q;

    assign in_ready  = rdy;
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = out_q;
    assign acc       = in_valid & rdy;
    assign drn       = out_valid & out_ready;
    assign load_out  = (acc & ((state == ST_EMPTY) | drn)) | ((state == ST_FULL) & drn);
    assign load_skid = acc & ~drn & (state == ST_HALF);

    always_comb begin
        state_nxt = (state == ST_EMPTY) ? (acc ? ST_HALF : ST_EMPTY) :
                    (state == ST_HALF)  ? ((acc & ~drn) ? ST_FULL : (~acc & drn) ? ST_EMPTY : ST_HALF) :
                    (drn ? ST_HALF : ST_FULL);
    end

    // in_ready comes from the next state so it is a pure register output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            rdy    <= 1'b1;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            rdy   <= (state_nxt != ST_FULL);
            if (load_out) out_q <= (state == ST_FULL) ? skid_q : in_data;
            if (load_skid) skid_q <= in_data;
        end
    end
endmodule

// File: rtl/diff_wb_stage.sv
// diff_wb_stage: writeback of diff-operator results with equal-result flag/counter.
// Optional result legality checker enabled by DIFF_WB_CHECK_EN.
module diff_wb_stage
    import diff_wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_diff,
    input  logic [RD_W-1:0]   in_rd,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              eq_flag,
    output logic [CNT_W-1:0]  eq_count,
    output logic              err
);
    logic              acc, is_eq, bad;
    logic [DATA_W-1:0] fwd;

    assign acc   = in_valid & in_ready;
    assign is_eq = (in_diff == DATA_W'(DIFF_EQUAL));

`ifdef DIFF_WB_CHECK_EN
    assign bad = (in_diff[DATA_W-1:6] != '0) | (in_diff[5:0] > 6'(DIFF_EQUAL));
    assign fwd = bad ? '1 : in_diff;

    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else if (acc & bad) err <= 1'b1;
    end
`else
    assign bad = 1'b0;
    assign fwd = in_diff;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            eq_flag  <= 1'b0;
            eq_count <= '0;
        end else if (acc) begin
            eq_flag <= is_eq & ~bad;
            if (is_eq & ~&eq_count) eq_count <= eq_count + 1'b1;
        end
    end

    skid_buffer2 #(.W(RD_W + DATA_W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({in_rd, fwd}),
        .out_valid(wb_valid),
        .out_ready(wb_ready),
        .out_data ({wb_rd, wb_data})
    );
endmodule

// File: tb/tb_diff_wb_stage.sv
// tb_diff_wb_stage: directed table, corner sequences and random run against a queue model.
module tb_diff_wb_stage;
`ifdef DIFF_WB_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, wb_ready = 1'b0;
    logic [31:0] in_diff = '0;
    logic [4:0]  in_rd = '0;
    logic        in_ready, wb_valid, eq_flag, err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [7:0]  eq_count;
    logic        in_ready2, wb_valid2, eq_flag2, err2;
    logic [4:0]  wb_rd2;
    logic [31:0] wb_data2;
    logic [1:0]  eq_count2;

    int checks = 0, failures = 0;

    logic [36:0] q[$];
    bit          m_eq, m_err;
    int          m_cnt, m_cnt2;

    always #5 clk = ~clk;

    diff_wb_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_diff(in_diff), .in_rd(in_rd), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .eq_flag(eq_flag), .eq_count(eq_count), .err(err)
    );

    diff_wb_stage #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_diff(in_diff), .in_rd(in_rd), .wb_valid(wb_valid2), .wb_ready(wb_ready),
        .wb_rd(wb_rd2), .wb_data(wb_data2), .eq_flag(eq_flag2), .eq_count(eq_count2), .err(err2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the buffer is a FIFO of at most two entries; ready while fewer than two.
    task automatic step();
        bit acc, drn, bad;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_eq = 0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            acc = in_valid && (q.size() < 2);
            drn = (q.size() > 0) && wb_ready;
            if (drn) void'(q.pop_front());
            if (acc) begin
                bad = CHECK && (in_diff > 32);
                q.push_back({in_rd, bad ? 32'hFFFF_FFFF : in_diff});
                if (bad) m_err = 1;
                m_eq = !bad && (in_diff == 32);
                if (in_diff == 32) begin
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end
        end
        #1;
    endtask

    task automatic mcheck();
        chk("m_in_ready", in_ready, q.size() < 2);
        chk("m_wb_valid", wb_valid, q.size() > 0);
        chk("m2_in_ready", in_ready2, q.size() < 2);
        chk("m2_wb_valid", wb_valid2, q.size() > 0);
        if (q.size() > 0) begin
            chk("m_wb_rd", wb_rd, q[0][36:32]);
            chk("m_wb_data", wb_data, q[0][31:0]);
            chk("m2_wb_data", {wb_rd2, wb_data2}, q[0]);
        end
        chk("m_eq_flag", eq_flag, m_eq);
        chk("m2_eq_flag", eq_flag2, m_eq);
        chk("m_eq_count", eq_count, m_cnt);
        chk("m_eq_count2", eq_count2, m_cnt2);
        chk("m_err", err, m_err);
        chk("m2_err", err2, m_err);
    endtask

    typedef struct {
        bit v; logic [31:0] d; logic [4:0] rd; bit wr;
        bit rdy; bit wv; logic [4:0] erd; logic [31:0] edata; bit eq; int cnt; int cnt2;
    } vec_t;
    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1, 5,  3,  1, 1, 1, 3,  5,  0, 0, 0};
        tbl[1]  = '{0, 0,  0,  1, 1, 0, 0,  0,  0, 0, 0};
        tbl[2]  = '{1, 7,  1,  0, 1, 1, 1,  7,  0, 0, 0};
        tbl[3]  = '{1, 9,  2,  0, 0, 1, 1,  7,  0, 0, 0};
        tbl[4]  = '{1, 11, 4,  0, 0, 1, 1,  7,  0, 0, 0};
        tbl[5]  = '{0, 0,  0,  1, 1, 1, 2,  9,  0, 0, 0};
        tbl[6]  = '{0, 0,  0,  1, 1, 0, 0,  0,  0, 0, 0};
        tbl[7]  = '{1, 32, 5,  1, 1, 1, 5,  32, 1, 1, 1};
        tbl[8]  = '{1, 32, 6,  1, 1, 1, 6,  32, 1, 2, 2};
        tbl[9]  = '{1, 32, 7,  1, 1, 1, 7,  32, 1, 3, 3};
        tbl[10] = '{1, 32, 8,  1, 1, 1, 8,  32, 1, 4, 3};
        tbl[11] = '{1, 32, 9,  1, 1, 1, 9,  32, 1, 5, 3};
        tbl[12] = '{1, 0,  10, 1, 1, 1, 10, 0,  0, 5, 3};
        tbl[13] = '{0, 0,  0,  1, 1, 0, 0,  0,  0, 5, 3};

        step(); step();
        rst = 1'b0;
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_eq_flag", eq_flag, 0);
        chk("rst_eq_count", eq_count, 0);
        chk("rst_err", err, 0);

        for (int i = 0; i < 14; i++) begin
            in_valid = tbl[i].v; in_diff = tbl[i].d; in_rd = tbl[i].rd; wb_ready = tbl[i].wr;
            step();
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_wb_valid", i), wb_valid, tbl[i].wv);
            if (tbl[i].wv) begin
                chk($sformatf("tbl%0d_wb_rd", i), wb_rd, tbl[i].erd);
                chk($sformatf("tbl%0d_wb_data", i), wb_data, tbl[i].edata);
            end
            chk($sformatf("tbl%0d_eq_flag", i), eq_flag, tbl[i].eq);
            chk($sformatf("tbl%0d_eq_count", i), eq_count, tbl[i].cnt);
            chk($sformatf("tbl%0d_eq_count2", i), eq_count2, tbl[i].cnt2);
        end

        // Reset while FULL drops both pending entries.
        in_valid = 1; in_diff = 7; in_rd = 1; wb_ready = 0;
        step();
        in_diff = 9; in_rd = 2;
        step();
        chk("full_in_ready", in_ready, 0);
        chk("full_wb_data", wb_data, 7);
        in_valid = 0; rst = 1;
        step();
        chk("rstfull_wb_valid", wb_valid, 0);
        chk("rstfull_in_ready", in_ready, 1);
        chk("rstfull_eq_count", eq_count, 0);
        rst = 0; wb_ready = 1;
        step(); step();
        chk("rstfull_no_write", wb_valid, 0);

        // Out-of-range index.
        in_valid = 1; in_diff = 33; in_rd = 1;
        step();
        chk("ill_wb_valid", wb_valid, 1);
        chk("ill_wb_data", wb_data, CHECK ? 32'hFFFF_FFFF : 32'd33);
        chk("ill_err", err, CHECK);
        chk("ill_eq_flag", eq_flag, 0);
        chk("ill_eq_count", eq_count, 0);
        in_valid = 0;
        step();
        chk("ill_err_sticky", err, CHECK);

        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: in_diff = 32;
                1: in_diff = $urandom_range(0, 31);
                2: in_diff = $urandom_range(33, 63);
                default: in_diff = $urandom;
            endcase
            in_rd = 5'($urandom);
            wb_ready = ($urandom_range(0, 2) != 0);
            step();
            mcheck();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
